// File: rtl/data_sink.sv
// Multi-port consumer for {id, size} words: programmable back-pressure, in-order ID and
// size checking, completion tracking and a wrapping total-size accumulator.
module data_sink #(
    parameter int id_width_p       = 4,
    parameter int size_width_p     = 8,
    parameter int num_ports_p      = 2,
    parameter int workload_limit_p = 4,
    parameter int expected_size_p  = 0,
    parameter int accept_freq_p    = 0,
    parameter int sum_width_p      = 32,
    parameter int width_p          = id_width_p + size_width_p,
    parameter int port_width_lp    = (num_ports_p > 1) ? $clog2(num_ports_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_ports_p-1:0]         v_i,
    input  logic [num_ports_p*width_p-1:0] data_i,
    output logic [num_ports_p-1:0]         ready_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [port_width_lp-1:0]       err_port_o,
    output logic [sum_width_p-1:0]         total_size_o
);

    localparam logic [size_width_p-1:0] lp_exp_size  = size_width_p'(expected_size_p);
    localparam logic [31:0]             lp_limit     = 32'(workload_limit_p);
    localparam logic [31:0]             lp_freq_last = (accept_freq_p > 0) ? 32'(accept_freq_p - 1) : 32'd0;

    logic [num_ports_p-1:0][id_width_p-1:0] r_exp_id;
    logic [num_ports_p-1:0][31:0]           r_cnt;
    logic [num_ports_p-1:0][31:0]           r_freq_ctr;
    logic [num_ports_p-1:0]                 r_fin;
    logic [num_ports_p-1:0]                 r_ready;
    logic                                   r_done;
    logic                                   r_error;
    logic [port_width_lp-1:0]               r_err_port;
    logic [sum_width_p-1:0]                 r_total;

    logic [num_ports_p-1:0][id_width_p-1:0]   w_id;
    logic [num_ports_p-1:0][size_width_p-1:0] w_size;
    logic [num_ports_p-1:0]                   w_hs;
    logic [num_ports_p-1:0]                   w_err;
    logic [num_ports_p-1:0]                   w_fin_next;
    logic [sum_width_p-1:0]                   w_sum;
    logic [port_width_lp-1:0]                 w_first_err;

    // Per-port handshake decode, checks and the single-stage sum of accepted sizes;
    // scanning from the top port down lets the lowest failing index win.
    always_comb begin
        w_id        = '0;
        w_size      = '0;
        w_hs        = '0;
        w_err       = '0;
        w_fin_next  = '0;
        w_sum       = '0;
        w_first_err = '0;
        for (int i = num_ports_p - 1; i >= 0; i--) begin
            w_id[i]       = data_i[i*width_p+size_width_p +: id_width_p];
            w_size[i]     = data_i[i*width_p +: size_width_p];
            w_hs[i]       = v_i[i] & r_ready[i];
            w_err[i]      = w_hs[i] & ((w_id[i] != r_exp_id[i]) |
                            ((expected_size_p != 0) & (w_size[i] != lp_exp_size)));
            w_fin_next[i] = r_fin[i] | (w_hs[i] & ((r_cnt[i] + 32'd1) == lp_limit));
            if (w_hs[i]) begin
                w_sum = w_sum + sum_width_p'(w_size[i]);
            end else begin
                w_sum = w_sum;
            end
            if (w_err[i]) begin
                w_first_err = port_width_lp'(i);
            end else begin
                w_first_err = w_first_err;
            end
        end
    end

    // Port state, ready pulses, completion, sticky error capture and accumulation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_exp_id   <= '0;
            r_cnt      <= '0;
            r_freq_ctr <= '0;
            r_fin      <= '0;
            r_ready    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_port <= '0;
            r_total    <= '0;
        end else begin
            for (int i = 0; i < num_ports_p; i++) begin
                if (w_hs[i]) begin
                    r_exp_id[i] <= r_exp_id[i] + id_width_p'(1);
                    r_cnt[i]    <= r_cnt[i] + 32'd1;
                end else begin
                    r_exp_id[i] <= r_exp_id[i];
                    r_cnt[i]    <= r_cnt[i];
                end
                // With accept_freq_p = 0 the last value is 0, so the counter idles at 0.
                if (r_freq_ctr[i] == lp_freq_last) begin
                    r_freq_ctr[i] <= 32'd0;
                end else begin
                    r_freq_ctr[i] <= r_freq_ctr[i] + 32'd1;
                end
                r_fin[i] <= w_fin_next[i];
                if (w_fin_next[i]) begin
                    r_ready[i] <= 1'b0;
                end else if (accept_freq_p == 0) begin
                    r_ready[i] <= 1'b1;
                end else begin
                    r_ready[i] <= (r_freq_ctr[i] == lp_freq_last);
                end
            end
            r_done  <= &r_fin;
            r_error <= r_error | (|w_err);
            if (!r_error && (|w_err)) begin
                r_err_port <= w_first_err;
            end else begin
                r_err_port <= r_err_port;
            end
            r_total <= r_total + w_sum;
        end
    end

    assign ready_o      = r_ready;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign err_port_o   = r_err_port;
    assign total_size_o = r_total;

endmodule

// File: tb/tb_data_sink.sv
// Self-checking bench for data_sink: three configurations share one clock and reset;
// expected totals go through a scoreboard queue, other values come from a cycle model.
module tb_data_sink;

    logic        clk;
    logic        rst_n;

    logic [1:0]  v_a;
    logic [23:0] data_a;
    logic [1:0]  ready_a;
    logic        done_a, error_a;
    logic        err_port_a;
    logic [31:0] total_a;

    logic [0:0]  v_b;
    logic [11:0] data_b;
    logic [0:0]  ready_b;
    logic        done_b, error_b;
    logic        err_port_b;
    logic [31:0] total_b;

    logic [0:0]  v_c;
    logic [5:0]  data_c;
    logic [0:0]  ready_c;
    logic        done_c, error_c;
    logic        err_port_c;
    logic [31:0] total_c;

    int n_tests;
    int n_fail;
    int exp_q[$];

    data_sink #(.id_width_p(4), .size_width_p(8), .num_ports_p(2), .workload_limit_p(4),
                .expected_size_p(5), .accept_freq_p(0), .sum_width_p(32)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .data_i(data_a), .ready_o(ready_a),
        .done_o(done_a), .error_o(error_a), .err_port_o(err_port_a), .total_size_o(total_a));

    data_sink #(.id_width_p(4), .size_width_p(8), .num_ports_p(1), .workload_limit_p(4),
                .expected_size_p(0), .accept_freq_p(3), .sum_width_p(32)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_b), .data_i(data_b), .ready_o(ready_b),
        .done_o(done_b), .error_o(error_b), .err_port_o(err_port_b), .total_size_o(total_b));

    data_sink #(.id_width_p(2), .size_width_p(4), .num_ports_p(1), .workload_limit_p(6),
                .expected_size_p(0), .accept_freq_p(0), .sum_width_p(32)) dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_c), .data_i(data_c), .ready_o(ready_c),
        .done_o(done_c), .error_o(error_c), .err_port_o(err_port_c), .total_size_o(total_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] wa(input int id, input int sz);
        return {4'(id), 8'(sz)};
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        v_a    = 2'b00; data_a = 24'h0;
        v_b    = 1'b0;  data_b = 12'h0;
        v_c    = 1'b0;  data_c = 6'h0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v_a = 2'b11; data_a = {wa(0, 5), wa(0, 5)};
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ready_a, done_a, error_a, err_port_a, total_a} !== 37'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ready_a, done_a, error_a, err_port_a, total_a});
        end
        rst_n = 1'b1;
        n_tests++;
        if (ready_a !== 2'b00) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 00", ready_a); end
        @(negedge clk);
        n_tests++;
        if (ready_a !== 2'b11) begin n_fail++; $display("FAIL reset_ready_rise: got %b expected 11", ready_a); end
        v_a = 2'b00;
    endtask

    task automatic test_stream();
        int exp_total;
        int e;
        do_reset();
        @(negedge clk);
        exp_total = 0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (ready_a !== 2'b11) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 11", k, ready_a); end
            v_a = 2'b11; data_a = {wa(k, 5), wa(k, 5)};
            exp_total += 10;
            exp_q.push_back(exp_total);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (total_a !== 32'(e)) begin n_fail++; $display("FAIL stream_total[%0d]: got %0d expected %0d", k, total_a, e); end
        end
        n_tests++;
        if ({ready_a, done_a} !== 3'b000) begin n_fail++; $display("FAIL stream_finish: got ready=%b done=%b expected 00/0", ready_a, done_a); end
        data_a = {wa(4, 9), wa(4, 9)};
        @(negedge clk);
        n_tests++;
        if ({done_a, error_a} !== 2'b10) begin n_fail++; $display("FAIL stream_done: got done=%b err=%b expected 1/0", done_a, error_a); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (ready_a !== 2'b00 || total_a !== 32'd40 || done_a !== 1'b1) begin
                n_fail++; $display("FAIL post_finish[%0d]: got ready=%b total=%0d done=%b expected 00/40/1", k, ready_a, total_a, done_a);
            end
        end
        v_a = 2'b00;
    endtask

    task automatic test_errors();
        do_reset();
        @(negedge clk);
        v_a = 2'b11; data_a = {wa(0, 5), wa(0, 5)};
        @(negedge clk);
        n_tests++;
        if (error_a !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b expected 0", error_a); end
        data_a = {wa(2, 5), wa(1, 7)};
        @(negedge clk);
        n_tests++;
        if (error_a !== 1'b1 || err_port_a !== 1'b0 || total_a !== 32'd22) begin
            n_fail++; $display("FAIL err_first: got err=%b port=%b total=%0d expected 1/0/22", error_a, err_port_a, total_a);
        end
        data_a = {wa(9, 5), wa(2, 5)};
        @(negedge clk);
        n_tests++;
        if (error_a !== 1'b1 || err_port_a !== 1'b0 || total_a !== 32'd32) begin
            n_fail++; $display("FAIL err_sticky: got err=%b port=%b total=%0d expected 1/0/32", error_a, err_port_a, total_a);
        end
        v_a = 2'b00;
    endtask

    task automatic test_freq();
        int hs;
        int tot;
        int e;
        logic exp_rdy;
        do_reset();
        v_b = 1'b1;
        hs  = 0;
        tot = 0;
        for (int c = 0; c < 16; c++) begin
            exp_rdy = (c > 0) && (c % 3 == 0) && (hs < 4);
            n_tests++;
            if (ready_b !== exp_rdy) begin n_fail++; $display("FAIL freq_ready[c%0d]: got %b expected %b", c, ready_b, exp_rdy); end
            n_tests++;
            if (done_b !== (c >= 14)) begin n_fail++; $display("FAIL freq_done[c%0d]: got %b expected %b", c, done_b, (c >= 14)); end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (total_b !== 32'(e)) begin n_fail++; $display("FAIL freq_total[c%0d]: got %0d expected %0d", c, total_b, e); end
            end
            data_b = {4'(hs), 8'(hs + 1)};
            if (exp_rdy) begin
                hs++;
                tot += hs;
                exp_q.push_back(tot);
            end
            @(negedge clk);
        end
        n_tests++;
        if (error_b !== 1'b0 || total_b !== 32'd10) begin n_fail++; $display("FAIL freq_end: got err=%b total=%0d expected 0/10", error_b, total_b); end
        v_b = 1'b0;
    endtask

    task automatic test_id_wrap();
        int e;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (ready_c !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected 1", k, ready_c); end
            v_c = 1'b1; data_c = {2'(k % 4), 4'd3};
            exp_q.push_back(3 * (k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (total_c !== 32'(e) || error_c !== 1'b0) begin
                n_fail++; $display("FAIL wrap_step[%0d]: got total=%0d err=%b expected %0d/0", k, total_c, error_c, e);
            end
        end
        v_c = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done_c !== 1'b1 || error_c !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got done=%b err=%b expected 1/0", done_c, error_c); end
    endtask

    task automatic test_midstream_reset();
        int e;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            v_a = 2'b11; data_a = {wa(k, 5), wa(k, 5)};
            @(negedge clk);
        end
        n_tests++;
        if (total_a !== 32'd20) begin n_fail++; $display("FAIL mid_pre_total: got %0d expected 20", total_a); end
        data_a = {wa(2, 5), wa(2, 5)};
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ready_a, done_a, error_a, err_port_a, total_a} !== 37'h0) begin
            n_fail++; $display("FAIL mid_async_clear: got %h expected 0", {ready_a, done_a, error_a, err_port_a, total_a});
        end
        @(negedge clk);
        rst_n = 1'b1; v_a = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            v_a = 2'b11; data_a = {wa(k, 5), wa(k, 5)};
            exp_q.push_back(10 * (k + 1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (total_a !== 32'(e) || error_a !== 1'b0) begin
                n_fail++; $display("FAIL mid_restart[%0d]: got total=%0d err=%b expected %0d/0", k, total_a, error_a, e);
            end
        end
        v_a = 2'b00;
        @(negedge clk);
        n_tests++;
        if (done_a !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b expected 1", done_a); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        v_a = 2'b00; data_a = 24'h0;
        v_b = 1'b0;  data_b = 12'h0;
        v_c = 1'b0;  data_c = 6'h0;
        test_reset();
        test_stream();
        test_errors();
        test_freq();
        test_id_wrap();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
